seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational datapath ALU.
- WIDTH-bit operands, eight operations including shifts and an iterative shift-add multiply.
- Registered result and NZCV flags; valid/ready on both sides so the control unit can stall on multi-cycle ops.
- Sits between the register-file read stage and write-back.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- in_clk  input  1  clock; all state updates on rising edge
- in_rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operation request valid
- out_ready  output  1  block can accept a request (high only in IDLE)
- in_op_sel  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL
- in_operand_1  input  WIDTH  first operand
- in_operand_2  input  WIDTH  second operand / shift amount
- out_valid  output  1  result and flags valid
- in_ready  input  1  consumer accepts result
- out_result  output  WIDTH  registered result
- out_flags  output  4  {N, Z, C, V}, registered with the result

Behaviour:
- States: IDLE, MUL, RESP.
- Reset (in_rst_n low at an edge):
  - state = IDLE; out_result, out_flags, out_valid = 0; multiplier accumulator/counter cleared.
  - Reset aborts any in-flight op, including mid-MUL; nothing is emitted afterwards.
- out_ready = (state == IDLE), combinational from state only.
- Accept: in_valid && out_ready at an edge; operands and op are captured. Inputs are ignored in all other cycles.
- Ops 0-6 (IDLE -> RESP):
  - Result computed from the captured inputs at the accept edge.
  - out_valid = 1 from the next cycle (latency 1).
- Op 7 (IDLE -> MUL):
  - Unsigned shift-add over WIDTH iterations, one per cycle, into a 2*WIDTH accumulator.
  - After the WIDTH-th iteration -> RESP.
  - out_valid rises WIDTH+1 cycles after the accept edge.
- RESP:
  - out_valid = 1; out_result and out_flags held stable while in_ready = 0.
  - out_valid && in_ready -> IDLE.
  - A new request can be accepted no earlier than the cycle after the handshake (max 1 op / 2 cycles).
- Arithmetic (all results mod 2^WIDTH):
  - ADD: C = carry out; V = signed overflow (operands same sign, result differs).
  - SUB (op1 - op2): C = borrow (1 iff op1 < op2 unsigned); V = signed overflow (operand signs differ, result sign != op1 sign).
  - AND/OR/XOR: C = 0, V = 0.
  - SLL/SRL: amount = operand_2[SHW-1:0], upper bits ignored; logical (zero fill). C = last bit shifted out, 0 when amount = 0. V = 0.
  - MUL: result = low WIDTH bits of product; C = 1 iff the high WIDTH bits are nonzero; V = 0.
  - All ops: N = result[WIDTH-1]; Z = (result == 0).
- Boundaries:
  - in_valid while out_ready = 0: no effect; requester holds.
  - in_ready high outside RESP: ignored.
  - Multiply by 0 still takes WIDTH cycles (fixed latency).

Decomposition:
- Package seq_alu_pkg:
  - op-select constants/enum (OP_ADD..OP_MUL);
  - state enum (ST_IDLE, ST_MUL, ST_RESP);
  - flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module: seq_multiplier (start, operands, WIDTH-cycle shift-add, done pulse, 2*WIDTH product). Top holds FSM, single-cycle datapath, and output/flag registers.

Test Plan:
- ADD 0xFFFF + 0x0001, in_ready = 1 -> one cycle later out_valid = 1, out_result = 0x0000, flags N0 Z1 C1 V0; out_ready high the following cycle.
- SUB 0x8000 - 0x0001 -> out_result = 0x7FFF, N0 Z0 C0 V1; SUB 0x0001 - 0x0002 -> 0xFFFF, N1 Z0 C1 V0.
- SLL 0x8001 by operand_2 = 0x0011 (amount 1) -> 0x0002, C = 1; SRL 0x0003 by 0 -> 0x0003, C = 0.
- MUL 0x0123 * 0x0010 -> out_valid exactly 17 cycles after accept, 0x1230, C0; MUL 0x1000 * 0x0010 -> 0x0000, Z1 C1; out_ready = 0 throughout; in_valid pulses during MUL ignored.
- Backpressure: XOR 0x00FF ^ 0x0F0F with in_ready = 0 for 3 cycles -> out_valid and out_result = 0x0FF0 held stable; IDLE the cycle after in_ready = 1.
- Assert in_rst_n = 0 for one edge at MUL iteration 5 -> next cycle IDLE, out_valid = 0, out_result = 0, out_flags = 0; no result emitted afterwards.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the handshaked sequential ALU: op codes, FSM states, flag layout.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: the first iteration happens on the start edge,
// the remaining WIDTH-1 on following edges; done pulses once the product is final.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [SHW-1:0]     count_reg;
  logic               busy_reg;
  logic               done_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        // Iteration 1 folded into the load so the total is exactly WIDTH edges.
        acc_reg    <= multiplier[0] ? {{WIDTH{1'b0}}, multiplicand} : '0;
        mcand_reg  <= {{(WIDTH-1){1'b0}}, multiplicand, 1'b0};
        mplier_reg <= multiplier >> 1;
        count_reg  <= SHW'(1);
        busy_reg   <= 1'b1;
      end else if (busy_reg) begin
        if (mplier_reg[0]) begin
          acc_reg <= acc_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + SHW'(1);
        if (count_reg == SHW'(WIDTH-1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU between register read and write-back: single-cycle logic/arith/shift
// ops, a WIDTH-cycle multiply, and a registered result with NZCV flags.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [2:0]       in_op_sel,
  input  logic [WIDTH-1:0] in_operand_1,
  input  logic [WIDTH-1:0] in_operand_2,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  state_e state_reg, state_next;
  op_e    op;
  logic   accept;
  logic   mul_start;
  logic   mul_done;

  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum_ext, diff_ext;
  logic [2*WIDTH-1:0] sll_ext, srl_ext;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry, alu_ovf;
  logic [3:0]         alu_flags, mul_flags;
  logic [WIDTH-1:0]   result_reg;
  logic [3:0]         flags_reg;

  assign op        = op_e'(in_op_sel);
  assign out_ready = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_RESP);
  assign accept    = in_valid && out_ready;
  assign mul_start = accept && (op == OP_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk          (in_clk),
    .rst_n        (in_rst_n),
    .start        (mul_start),
    .multiplicand (in_operand_1),
    .multiplier   (in_operand_2),
    .done         (mul_done),
    .product      (mul_product)
  );

  // Shifting through a double-width window leaves the last bit shifted out at a fixed index.
  assign shamt    = in_operand_2[SHW-1:0];
  assign sum_ext  = {1'b0, in_operand_1} + {1'b0, in_operand_2};
  assign diff_ext = {1'b0, in_operand_1} - {1'b0, in_operand_2};
  assign sll_ext  = {{WIDTH{1'b0}}, in_operand_1} << shamt;
  assign srl_ext  = {in_operand_1, {WIDTH{1'b0}}} >> shamt;

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        alu_result = sum_ext[WIDTH-1:0];
        alu_carry  = sum_ext[WIDTH];
        alu_ovf    = (in_operand_1[WIDTH-1] == in_operand_2[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != in_operand_1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result = diff_ext[WIDTH-1:0];
        alu_carry  = diff_ext[WIDTH];
        alu_ovf    = (in_operand_1[WIDTH-1] != in_operand_2[WIDTH-1]) &&
                     (diff_ext[WIDTH-1] != in_operand_1[WIDTH-1]);
      end
      OP_AND: alu_result = in_operand_1 & in_operand_2;
      OP_OR:  alu_result = in_operand_1 | in_operand_2;
      OP_XOR: alu_result = in_operand_1 ^ in_operand_2;
      OP_SLL: begin
        alu_result = sll_ext[WIDTH-1:0];
        alu_carry  = sll_ext[WIDTH];
      end
      OP_SRL: begin
        alu_result = srl_ext[2*WIDTH-1:WIDTH];
        alu_carry  = srl_ext[WIDTH-1];
      end
      default: ;
    endcase
  end

  assign alu_flags = pack_flags(alu_result[WIDTH-1], alu_result == '0, alu_carry, alu_ovf);
  assign mul_flags = pack_flags(mul_product[WIDTH-1], mul_product[WIDTH-1:0] == '0,
                                |mul_product[2*WIDTH-1:WIDTH], 1'b0);

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (op == OP_MUL) ? ST_MUL : ST_RESP;
        end
      end
      ST_MUL:  if (mul_done) state_next = ST_RESP;
      ST_RESP: if (in_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      result_reg <= '0;
      flags_reg  <= '0;
    end else if (accept && (op != OP_MUL)) begin
      result_reg <= alu_result;
      flags_reg  <= alu_flags;
    end else if ((state_reg == ST_MUL) && mul_done) begin
      result_reg <= mul_product[WIDTH-1:0];
      flags_reg  <= mul_flags;
    end
  end

  assign out_result = result_reg;
  assign out_flags  = flags_reg;

endmodule
